alu_core: RTL and testbench

- Parameterised n-bit integer ALU with registered result and flags (one-cycle latency).
- Performs add/subtract with and without carry-in, bitwise logic, shifts and rotates, selected by a 7-bit opcode.
- Sits in the datapath execute stage. Flags feed the condition/branch logic.
- One clock; reset is synchronous and active-high.

---
 rtl/alu_core.sv | 128 ++++++++++++
 tb/tb_alu_core.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// alu_core: N-bit integer ALU for the execute stage; result and flags are registered
// (one-cycle latency, a new operation may issue every cycle).
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   a, b          operands; b is also the unsigned shift/rotate amount
//   op            7-bit opcode (0..13 defined, others yield zero)
//   cin           carry/borrow in, used by ADC and SBC only
//   out           registered result
//   cout          registered carry (ADD/ADC) or borrow (SUB/SBC)
//   overflow      registered two's-complement overflow
//   sign, zero    registered out[N-1] and (out == 0)
module alu_core #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [6:0]   op,
    input  logic         cin,
    output logic [N-1:0] out,
    output logic         cout,
    output logic         overflow,
    output logic         sign,
    output logic         zero
);

    // Shift amounts are handled at least 32 bits wide so N itself is representable.
    localparam int unsigned BW = (N > 32) ? N : 32;

    localparam logic [6:0] OP_ADD   = 7'd0;
    localparam logic [6:0] OP_ADC   = 7'd1;
    localparam logic [6:0] OP_SUB   = 7'd2;
    localparam logic [6:0] OP_SBC   = 7'd3;
    localparam logic [6:0] OP_AND   = 7'd4;
    localparam logic [6:0] OP_OR    = 7'd5;
    localparam logic [6:0] OP_XOR   = 7'd6;
    localparam logic [6:0] OP_NOT   = 7'd7;
    localparam logic [6:0] OP_LSL   = 7'd8;
    localparam logic [6:0] OP_LSR   = 7'd9;
    localparam logic [6:0] OP_ASR   = 7'd10;
    localparam logic [6:0] OP_ROL   = 7'd11;
    localparam logic [6:0] OP_ROR   = 7'd12;
    localparam logic [6:0] OP_PASSB = 7'd13;

    logic [N-1:0] out_q, out_d;
    logic         cout_q, cout_d;
    logic         overflow_q, overflow_d;
    logic         sign_q, sign_d;
    logic         zero_q, zero_d;

    logic         cin_eff;
    logic [N:0]   sum;
    logic [N:0]   diff;
    logic [BW-1:0] b_ext;
    logic [BW-1:0] rot_amt;

    // Result and flag computation for the operation presented this cycle.
    always_comb begin
        out_d      = '0;
        cout_d     = 1'b0;
        overflow_d = 1'b0;

        cin_eff = ((op == OP_ADC) || (op == OP_SBC)) ? cin : 1'b0;
        // Extra top bit carries out of the add and signals borrow on the subtract.
        sum     = {1'b0, a} + {1'b0, b} + (N+1)'(cin_eff);
        diff    = {1'b0, a} - {1'b0, b} - (N+1)'(cin_eff);
        b_ext   = BW'(b);
        rot_amt = b_ext % BW'(N);

        case (op)
            OP_ADD, OP_ADC: begin
                out_d      = sum[N-1:0];
                cout_d     = sum[N];
                overflow_d = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_SUB, OP_SBC: begin
                out_d      = diff[N-1:0];
                cout_d     = diff[N];
                overflow_d = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
            end
            OP_AND:   out_d = a & b;
            OP_OR:    out_d = a | b;
            OP_XOR:   out_d = a ^ b;
            OP_NOT:   out_d = ~a;
            // Shift counts of N or more fall out naturally: zeros, or sign fill for ASR.
            OP_LSL:   out_d = a << b_ext;
            OP_LSR:   out_d = a >> b_ext;
            OP_ASR:   out_d = N'($signed(a) >>> b_ext);
            // A zero rotate shifts the complementary term by N, which yields zero.
            OP_ROL:   out_d = (a << rot_amt) | (a >> (BW'(N) - rot_amt));
            OP_ROR:   out_d = (a >> rot_amt) | (a << (BW'(N) - rot_amt));
            OP_PASSB: out_d = b;
            default: begin
                out_d      = '0;
                cout_d     = 1'b0;
                overflow_d = 1'b0;
            end
        endcase

        sign_d = out_d[N-1];
        zero_d = (out_d == '0);
    end

    // Output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
            sign_q     <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            out_q      <= out_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
            sign_q     <= sign_d;
            zero_q     <= zero_d;
        end
    end

    assign out      = out_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;
    assign sign     = sign_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core (N=8): hand-computed results and flags.
module tb_alu_core;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic [6:0] op;
    logic       cin;
    logic [7:0] out;
    logic       cout;
    logic       overflow;
    logic       sign;
    logic       zero;

    int n_vec;
    int n_err;

    // One directed vector: stimulus then expected out, cout, overflow, sign, zero.
    typedef struct packed {
        logic [6:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] o;
        logic       c;
        logic       v;
        logic       s;
        logic       z;
    } vec_t;

    alu_core #(.N(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .op       (op),
        .cin      (cin),
        .out      (out),
        .cout     (cout),
        .overflow (overflow),
        .sign     (sign),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operation and step to just after the edge that registers it.
    task automatic issue(input logic [6:0] op_i, input logic [7:0] a_i,
                         input logic [7:0] b_i, input logic cin_i);
        op  = op_i;
        a   = a_i;
        b   = b_i;
        cin = cin_i;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] got;
        rst = 1'b1;
        issue(7'd0, 8'd255, 8'd1, 1'b0);
        got = {out, cout, overflow, sign, zero};
        n_vec++;
        if (got !== 12'h000) begin
            n_err++;
            $display("FAIL reset_hold: got {out,c,v,s,z}=%h required 000", got);
        end
        rst = 1'b0;
        issue(7'd0, 8'd255, 8'd1, 1'b0);
        got = {out, cout, overflow, sign, zero};
        n_vec++;
        if (got !== {8'h00, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_release: got {out,c,v,s,z}=%h required %h",
                     got, {8'h00, 4'b1001});
        end
        // Reset in the middle of traffic clears the registered result.
        issue(7'd0, 8'd127, 8'd1, 1'b0);
        rst = 1'b1;
        issue(7'd0, 8'd127, 8'd1, 1'b0);
        got = {out, cout, overflow, sign, zero};
        n_vec++;
        if (got !== 12'h000) begin
            n_err++;
            $display("FAIL reset_midstream: got {out,c,v,s,z}=%h required 000", got);
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        vec_t v [10];
        logic [11:0] got;
        logic [11:0] exp;
        v = '{
            '{7'd0, 8'd1,   8'd1,   1'b0, 8'd2,   1'b0, 1'b0, 1'b0, 1'b0},
            '{7'd0, 8'd255, 8'd1,   1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 1'b1},
            '{7'd0, 8'd255, 8'd2,   1'b0, 8'd1,   1'b1, 1'b0, 1'b0, 1'b0},
            '{7'd0, 8'd255, 8'd255, 1'b0, 8'd254, 1'b1, 1'b0, 1'b1, 1'b0},
            '{7'd1, 8'd255, 8'd0,   1'b1, 8'd0,   1'b1, 1'b0, 1'b0, 1'b1},
            '{7'd0, 8'd127, 8'd1,   1'b0, 8'd128, 1'b0, 1'b1, 1'b1, 1'b0},
            '{7'd0, 8'd127, 8'd127, 1'b0, 8'd254, 1'b0, 1'b1, 1'b1, 1'b0},
            '{7'd0, 8'd255, 8'd1,   1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 1'b1},
            '{7'd0, 8'd1,   8'd1,   1'b1, 8'd2,   1'b0, 1'b0, 1'b0, 1'b0},
            '{7'd1, 8'd1,   8'd1,   1'b1, 8'd3,   1'b0, 1'b0, 1'b0, 1'b0}
        };
        for (int i = 0; i < 10; i++) begin
            issue(v[i].op, v[i].a, v[i].b, v[i].cin);
            got = {out, cout, overflow, sign, zero};
            exp = {v[i].o, v[i].c, v[i].v, v[i].s, v[i].z};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL add[%0d] op=%0d a=%h b=%h cin=%b: got {out,c,v,s,z}=%h required %h",
                         i, v[i].op, v[i].a, v[i].b, v[i].cin, got, exp);
            end
        end
    endtask

    task automatic test_sub();
        vec_t v [8];
        logic [11:0] got;
        logic [11:0] exp;
        v = '{
            '{7'd2, 8'd1,   8'd1, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b1},
            '{7'd2, 8'd1,   8'd2, 1'b0, 8'd255, 1'b1, 1'b0, 1'b1, 1'b0},
            '{7'd2, 8'd255, 8'd2, 1'b0, 8'd253, 1'b0, 1'b0, 1'b1, 1'b0},
            '{7'd2, 8'd128, 8'd1, 1'b0, 8'd127, 1'b0, 1'b1, 1'b0, 1'b0},
            '{7'd3, 8'd5,   8'd2, 1'b1, 8'd2,   1'b0, 1'b0, 1'b0, 1'b0},
            '{7'd3, 8'd2,   8'd2, 1'b1, 8'd255, 1'b1, 1'b0, 1'b1, 1'b0},
            '{7'd2, 8'd5,   8'd2, 1'b1, 8'd3,   1'b0, 1'b0, 1'b0, 1'b0},
            '{7'd2, 8'd127, 8'd255, 1'b0, 8'd128, 1'b1, 1'b1, 1'b1, 1'b0}
        };
        for (int i = 0; i < 8; i++) begin
            issue(v[i].op, v[i].a, v[i].b, v[i].cin);
            got = {out, cout, overflow, sign, zero};
            exp = {v[i].o, v[i].c, v[i].v, v[i].s, v[i].z};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL sub[%0d] op=%0d a=%h b=%h cin=%b: got {out,c,v,s,z}=%h required %h",
                         i, v[i].op, v[i].a, v[i].b, v[i].cin, got, exp);
            end
        end
    endtask

    task automatic test_shift_rotate();
        vec_t v [12];
        logic [11:0] got;
        logic [11:0] exp;
        v = '{
            '{7'd8,  8'h3A, 8'd2, 1'b1, 8'hE8, 1'b0, 1'b0, 1'b1, 1'b0},
            '{7'd9,  8'h3A, 8'd2, 1'b0, 8'h0E, 1'b0, 1'b0, 1'b0, 1'b0},
            '{7'd10, 8'hBA, 8'd2, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b0},
            '{7'd8,  8'hBA, 8'd9, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1},
            '{7'd9,  8'hBA, 8'd8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1},
            '{7'd10, 8'hBA, 8'd9, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0},
            '{7'd10, 8'h3A, 8'd9, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1},
            '{7'd8,  8'h3A, 8'd0, 1'b0, 8'h3A, 1'b0, 1'b0, 1'b0, 1'b0},
            '{7'd11, 8'h81, 8'd1, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0},
            '{7'd12, 8'h81, 8'd1, 1'b0, 8'hC0, 1'b0, 1'b0, 1'b1, 1'b0},
            '{7'd11, 8'h81, 8'd9, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0},
            '{7'd12, 8'h3A, 8'd8, 1'b0, 8'h3A, 1'b0, 1'b0, 1'b0, 1'b0}
        };
        for (int i = 0; i < 12; i++) begin
            issue(v[i].op, v[i].a, v[i].b, v[i].cin);
            got = {out, cout, overflow, sign, zero};
            exp = {v[i].o, v[i].c, v[i].v, v[i].s, v[i].z};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL shift[%0d] op=%0d a=%h b=%0d: got {out,c,v,s,z}=%h required %h",
                         i, v[i].op, v[i].a, v[i].b, got, exp);
            end
        end
    endtask

    task automatic test_logic_illegal();
        vec_t v [8];
        logic [11:0] got;
        logic [11:0] exp;
        v = '{
            '{7'd4,   8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0},
            '{7'd5,   8'hF0, 8'h3C, 1'b0, 8'hFC, 1'b0, 1'b0, 1'b1, 1'b0},
            '{7'd6,   8'hF0, 8'h3C, 1'b0, 8'hCC, 1'b0, 1'b0, 1'b1, 1'b0},
            '{7'd7,   8'hF0, 8'h3C, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0},
            '{7'd13,  8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0},
            '{7'd100, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1},
            '{7'd14,  8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1},
            '{7'd127, 8'h80, 8'h80, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}
        };
        for (int i = 0; i < 8; i++) begin
            issue(v[i].op, v[i].a, v[i].b, v[i].cin);
            got = {out, cout, overflow, sign, zero};
            exp = {v[i].o, v[i].c, v[i].v, v[i].s, v[i].z};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL logic[%0d] op=%0d a=%h b=%h: got {out,c,v,s,z}=%h required %h",
                         i, v[i].op, v[i].a, v[i].b, got, exp);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        a     = '0;
        b     = '0;
        op    = '0;
        cin   = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_sub();
        test_shift_rotate();
        test_logic_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
